led_count_monitor: RTL and testbench

Receive-side checker for the 8-bit LED counter bus. It samples a free-running count driven by a counter board that may be remote or on another clock domain, and filters it for stability. It reports each new value and verifies that every step is exactly +1 (mod 256) and that the step period equals CLK_FREQ cycles within a tolerance. Its lock, stall and error outputs drive status LEDs and a debug readout.

---
 rtl/led_count_monitor_if.sv | 25 ++
 rtl/led_count_monitor.sv | 143 ++++++++++++++
 tb/tb_led_count_monitor.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/led_count_monitor_if.sv
// LED counter bus as seen by the receive-side monitor: sampled count and clear in,
// status and debug readout out.
interface led_count_monitor_if;
    logic [7:0]  count_in;
    logic        clear;
    logic [7:0]  value_out;
    logic        value_valid;
    logic        locked;
    logic        stall;
    logic [15:0] step_err_cnt;
    logic [15:0] period_err_cnt;
    logic [31:0] last_period;

    modport slave (
        input  count_in, clear,
        output value_out, value_valid, locked, stall,
               step_err_cnt, period_err_cnt, last_period
    );

    modport master (
        output count_in, clear,
        input  value_out, value_valid, locked, stall,
               step_err_cnt, period_err_cnt, last_period
    );
endinterface

// File: rtl/led_count_monitor.sv
// Receive-side LED counter checker: synchronizes and debounces the asynchronous count,
// then tracks step (+1 mod 256) and period correctness with lock/stall/error reporting.
module led_count_monitor #(
    parameter int unsigned CLK_FREQ      = 25_000_000,
    parameter int unsigned TOLERANCE     = 2,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_count_monitor_if.slave   mon
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    localparam int unsigned    SW        = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0]  STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0]  STAB_MAX  = SW'(STABLE_CYCLES);
    localparam logic [32:0]    PER_HI    = 33'(CLK_FREQ) + 33'(TOLERANCE);
    localparam logic [32:0]    PER_LO    = (CLK_FREQ > TOLERANCE) ? 33'(CLK_FREQ - TOLERANCE) : 33'd0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) return v;
        else               return v + 16'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) return v;
        else                    return v + 32'd1;
    endfunction

    state_e        state_q, state_d;
    logic [7:0]    sync1_q, sync2_q, cand_q, cand_d, value_q, value_d;
    logic [SW-1:0] stab_q, stab_d;
    logic          valid_q, valid_d, locked_q, locked_d, stall_q, stall_d;
    logic [15:0]   step_err_q, step_err_d, period_err_q, period_err_d;
    logic [31:0]   last_period_q, last_period_d, period_q, period_d;
    logic          same_s, fire_s, accept_s, step_ok_s, period_ok_s, timeout_s;

    // Filter, step/period checks and FSM next-state for every register.
    always_comb begin
        same_s      = (sync2_q == cand_q);
        fire_s      = same_s ? (stab_q == STAB_LAST) : (STABLE_CYCLES == 32'd1);
        accept_s    = fire_s && ((state_q == ST_IDLE) || (sync2_q != value_q));
        step_ok_s   = (sync2_q == (value_q + 8'd1));
        period_ok_s = ({1'b0, period_q} >= PER_LO) && ({1'b0, period_q} <= PER_HI);
        // Threshold CLK_FREQ+TOLERANCE+1 is reached on the edge that increments past PER_HI.
        timeout_s   = ((state_q == ST_TRACK) || (state_q == ST_LOCKED)) && !accept_s
                      && ({1'b0, period_q} == PER_HI);

        cand_d        = sync2_q;
        stab_d        = same_s ? ((stab_q == STAB_MAX) ? stab_q : stab_q + SW'(1)) : SW'(1);
        state_d       = state_q;
        value_d       = value_q;
        valid_d       = 1'b0;
        stall_d       = stall_q;
        step_err_d    = step_err_q;
        period_err_d  = period_err_q;
        last_period_d = last_period_q;
        period_d      = sat_inc32(period_q);

        if (mon.clear) begin
            state_d      = ST_IDLE;
            step_err_d   = 16'd0;
            period_err_d = 16'd0;
            stall_d      = 1'b0;
        end else if (accept_s) begin
            value_d       = sync2_q;
            valid_d       = 1'b1;
            last_period_d = period_q;
            period_d      = 32'd1;
            stall_d       = 1'b0;
            case (state_q)
                ST_IDLE:    state_d = ST_ACQUIRE;
                ST_ACQUIRE: state_d = ST_TRACK;
                ST_TRACK, ST_LOCKED: begin
                    if (step_ok_s && period_ok_s) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_TRACK;
                        if (!step_ok_s) step_err_d = sat_inc16(step_err_q);
                        else            step_err_d = step_err_q;
                        if (!period_ok_s) period_err_d = sat_inc16(period_err_q);
                        else              period_err_d = period_err_q;
                    end
                end
                default:    state_d = ST_IDLE;
            endcase
        end else if (timeout_s) begin
            stall_d      = 1'b1;
            period_err_d = sat_inc16(period_err_q);
            state_d      = ST_ACQUIRE;
        end else begin
            state_d = state_q;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State, synchronizer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sync1_q       <= 8'd0;
            sync2_q       <= 8'd0;
            cand_q        <= 8'd0;
            stab_q        <= '0;
            value_q       <= 8'd0;
            valid_q       <= 1'b0;
            locked_q      <= 1'b0;
            stall_q       <= 1'b0;
            step_err_q    <= 16'd0;
            period_err_q  <= 16'd0;
            last_period_q <= 32'd0;
            period_q      <= 32'd0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= mon.count_in;
            sync2_q       <= sync1_q;
            cand_q        <= cand_d;
            stab_q        <= stab_d;
            value_q       <= value_d;
            valid_q       <= valid_d;
            locked_q      <= locked_d;
            stall_q       <= stall_d;
            step_err_q    <= step_err_d;
            period_err_q  <= period_err_d;
            last_period_q <= last_period_d;
            period_q      <= period_d;
        end
    end

    assign mon.value_out      = value_q;
    assign mon.value_valid    = valid_q;
    assign mon.locked         = locked_q;
    assign mon.stall          = stall_q;
    assign mon.step_err_cnt   = step_err_q;
    assign mon.period_err_cnt = period_err_q;
    assign mon.last_period    = last_period_q;
endmodule

// File: tb/tb_led_count_monitor.sv
// Directed plus randomized bench for led_count_monitor against a sample-history reference model.
module tb_led_count_monitor;
    localparam int CF  = 16;
    localparam int TOL = 1;
    localparam int SC  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_count_monitor_if mon();

    led_count_monitor #(.CLK_FREQ(CF), .TOLERANCE(TOL), .STABLE_CYCLES(SC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (mon)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0=idle 1=acquire 2=track 3=locked; hist holds raw samples, -1 = none.
    int     m_phase, m_value, m_valid, m_stall, m_serr, m_perr;
    longint m_last, m_per;
    int     hist[$];
    int     cur;

    task automatic model_reset();
        m_phase = 0; m_value = 0; m_valid = 0; m_stall = 0; m_serr = 0; m_perr = 0;
        m_last = 0; m_per = 0;
        hist = '{-1, 0, 0};
    endtask

    function automatic int hist_at(int k);
        int idx;
        idx = hist.size() - 1 - k;
        return (idx < 0) ? -1 : hist[idx];
    endfunction

    task automatic model_edge(int c, bit clr);
        int v; bit fire, acc, step_ok, per_ok; longint per_new;
        hist.push_back(c);
        if (hist.size() > 16) void'(hist.pop_front());
        // A value is accepted once it was sampled SC times in a row, reported two edges later.
        v = hist_at(2);
        fire = (v >= 0);
        for (int i = 0; i < SC; i++) if (hist_at(2 + i) != v) fire = 1'b0;
        if (hist_at(2 + SC) == v) fire = 1'b0;
        acc     = fire && (m_phase == 0 || v != m_value);
        step_ok = (v == ((m_value + 1) % 256));
        per_ok  = (m_per >= CF - TOL) && (m_per <= CF + TOL);
        per_new = (m_per < 64'hFFFF_FFFF) ? m_per + 1 : m_per;
        m_valid = 0;
        if (clr) begin
            m_phase = 0; m_serr = 0; m_perr = 0; m_stall = 0;
        end else if (acc) begin
            m_valid = 1; m_last = m_per; m_value = v; m_stall = 0; per_new = 1;
            if (m_phase < 2) m_phase = m_phase + 1;
            else if (step_ok && per_ok) m_phase = 3;
            else begin
                m_phase = 2;
                if (!step_ok && m_serr < 65535) m_serr = m_serr + 1;
                if (!per_ok && m_perr < 65535) m_perr = m_perr + 1;
            end
        end else if (m_phase >= 2 && per_new == CF + TOL + 1) begin
            m_stall = 1; m_phase = 1;
            if (m_perr < 65535) m_perr = m_perr + 1;
        end
        m_per = per_new;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("value_out",      32'(mon.value_out),      32'(m_value));
        chk("value_valid",    32'(mon.value_valid),    32'(m_valid));
        chk("locked",         32'(mon.locked),         32'(m_phase == 3));
        chk("stall",          32'(mon.stall),          32'(m_stall));
        chk("step_err_cnt",   32'(mon.step_err_cnt),   32'(m_serr));
        chk("period_err_cnt", 32'(mon.period_err_cnt), 32'(m_perr));
        chk("last_period",    mon.last_period,         32'(m_last));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(int'(mon.count_in), mon.clear);
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(int v, int n);
        mon.count_in = 8'(v);
        cur = v;
        repeat (n) tick();
    endtask

    task automatic pulse_clear();
        mon.clear = 1'b1;
        tick();
        mon.clear = 1'b0;
    endtask

    initial begin
        int r, n;
        mon.count_in = 8'h05;
        mon.clear    = 1'b0;
        cur = 5;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;

        // First value: exactly 2+STABLE_CYCLES edges of latency.
        repeat (5) tick();
        chk("valid_before_latency", 32'(mon.value_valid), 32'd0);
        tick();
        chk("valid_at_latency", 32'(mon.value_valid), 32'd1);
        chk("first_value", 32'(mon.value_out), 32'h05);
        chk("first_unlocked", 32'(mon.locked), 32'd0);
        hold(8'h05, 10);
        hold(8'h06, 16);
        hold(8'h07, 6);
        chk("lock_on_third", 32'(mon.locked), 32'd1);
        chk("period_16", mon.last_period, 32'd16);
        hold(8'h07, 10);

        // Wrap 0xFF -> 0x00 is a valid step.
        pulse_clear();
        hold(8'hFD, 16); hold(8'hFE, 16); hold(8'hFF, 16); hold(8'h00, 16);
        chk("wrap_locked", 32'(mon.locked), 32'd1);
        chk("wrap_no_step_err", 32'(mon.step_err_cnt), 32'd0);

        // Skipped value then recovery.
        pulse_clear();
        hold(8'h0E, 16); hold(8'h0F, 16); hold(8'h10, 16);
        hold(8'h12, 6);
        chk("skip_step_err", 32'(mon.step_err_cnt), 32'd1);
        chk("skip_unlocked", 32'(mon.locked), 32'd0);
        hold(8'h12, 10);
        hold(8'h13, 6);
        chk("skip_relock", 32'(mon.locked), 32'd1);
        hold(8'h13, 10);

        // Short period, then timeout and relock.
        hold(8'h14, 14);
        hold(8'h15, 6);
        chk("short_period_err", 32'(mon.period_err_cnt), 32'd1);
        chk("short_unlocked", 32'(mon.locked), 32'd0);
        hold(8'h15, 10); hold(8'h16, 16);
        hold(8'h17, 23);
        chk("timeout_stall", 32'(mon.stall), 32'd1);
        chk("timeout_period_err", 32'(mon.period_err_cnt), 32'd2);
        hold(8'h17, 17);
        chk("timeout_once", 32'(mon.period_err_cnt), 32'd2);
        hold(8'h18, 16);
        hold(8'h19, 6);
        chk("timeout_relock", 32'(mon.locked), 32'd1);
        chk("timeout_stall_clear", 32'(mon.stall), 32'd0);
        hold(8'h19, 10);

        // Glitch shorter than the filter window.
        hold(8'h55, 2);
        hold(8'h19, 12);

        // Clear on the acceptance edge discards the acceptance.
        hold(8'h1A, 5);
        pulse_clear();
        chk("clear_no_valid", 32'(mon.value_valid), 32'd0);
        chk("clear_unlocked", 32'(mon.locked), 32'd0);
        chk("clear_step_cnt", 32'(mon.step_err_cnt), 32'd0);
        chk("clear_period_cnt", 32'(mon.period_err_cnt), 32'd0);
        chk("clear_keeps_value", 32'(mon.value_out), 32'h19);
        hold(8'h1A, 10);

        // Randomized segments.
        for (int seg = 0; seg < 60; seg++) begin
            r = int'($urandom_range(0, 11));
            if (r < 6)       hold((cur + 1) % 256, int'($urandom_range(15, 17)));
            else if (r == 6) hold(int'($urandom_range(0, 255)), 16);
            else if (r == 7) hold((cur + 1) % 256, int'($urandom_range(8, 22)));
            else if (r == 8) begin
                n = cur;
                hold(int'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
                hold(n, 6);
            end else if (r == 9) begin
                hold((cur + 1) % 256, int'($urandom_range(2, 8)));
                pulse_clear();
                hold(cur, 8);
            end else if (r == 10) hold((cur + 1) % 256, int'($urandom_range(25, 40)));
            else             hold((cur + 1) % 256, 16);
        end

        // Asynchronous reset in the middle of a count.
        hold((cur + 1) % 256, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_value_out", 32'(mon.value_out), 32'd0);
        chk("rst_valid", 32'(mon.value_valid), 32'd0);
        chk("rst_locked", 32'(mon.locked), 32'd0);
        chk("rst_stall", 32'(mon.stall), 32'd0);
        chk("rst_step_cnt", 32'(mon.step_err_cnt), 32'd0);
        chk("rst_period_cnt", 32'(mon.period_err_cnt), 32'd0);
        chk("rst_last_period", mon.last_period, 32'd0);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        hold(cur, 20);
        hold((cur + 1) % 256, 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
